// File: rtl/mem_test_pkg.sv
// Shared types and pattern generator for the dual-port BRAM March tester.
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE, W0, RW1_RD, RW1_WR, RW2_RD, RW2_WR, R3, DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_ADDR    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_AW = 32;

  // Callers truncate the wide result to their own DATA_WIDTH.
  function automatic logic [MAX_DW-1:0] pattern(input logic [MAX_AW-1:0] addr,
                                                input mode_t mode,
                                                input logic invert);
    logic [MAX_DW-1:0] p;
    case (mode)
      MODE_CHECKER: p = addr[0] ? {(MAX_DW/2){2'b10}} : {(MAX_DW/2){2'b01}};
      MODE_ADDR:    p = MAX_DW'(addr);
      default:      p = '0;
    endcase
    return invert ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_test_checker.sv
// Compare stage: saturating mismatch counter and first-failure address capture.
module mem_test_checker
  import mem_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] actual,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  mismatch,
  output logic [ERR_WIDTH-1:0]  errorCount,
  output logic [ADDR_WIDTH-1:0] firstFailAddr
);

  assign mismatch = valid && (actual != expected);

  // The counter never wraps back to zero, so zero marks "no mismatch yet".
  always_ff @(posedge clk) begin
    if (!rst) begin
      errorCount    <= '0;
      firstFailAddr <= '0;
    end else if (clear) begin
      errorCount    <= '0;
      firstFailAddr <= '0;
    end else if (mismatch) begin
      if (errorCount != '1) errorCount <= errorCount + ERR_WIDTH'(1);
      if (errorCount == '0) firstFailAddr <= addr;
    end
  end

endmodule

// File: rtl/mem_march_tester.sv
// March test sequencer driving both ports of a true dual-port BRAM.
module mem_march_tester
  import mem_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] addressA,
  output logic [ADDR_WIDTH-1:0] addressB,
  output logic [DATA_WIDTH-1:0] dataInA,
  output logic [DATA_WIDTH-1:0] dataInB,
  output logic                  weA,
  output logic                  weB,
  input  logic [DATA_WIDTH-1:0] dataOutA,
  input  logic [DATA_WIDTH-1:0] dataOutB,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  errorCount,
  output logic [ADDR_WIDTH-1:0] firstFailAddr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                state;
  mode_t                 mode_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  drain;
  logic                  accept;
  logic                  cmp_valid;
  logic                  cmp_inv;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [DATA_WIDTH-1:0] cmp_actual;
  logic [DATA_WIDTH-1:0] cmp_expected;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  mismatch;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);

  always_comb begin
    cmp_valid  = 1'b0;
    cmp_inv    = 1'b0;
    cmp_addr   = cnt;
    cmp_actual = dataOutB;
    case (state)
      RW1_WR: cmp_valid = 1'b1;
      RW2_WR: begin
        cmp_valid = 1'b1;
        cmp_inv   = 1'b1;
      end
      R3: begin
        // Pipelined read: data arriving now belongs to the previous address.
        cmp_valid  = drain || (cnt != '0);
        cmp_addr   = drain ? cnt : cnt - ADDR_WIDTH'(1);
        cmp_actual = dataOutA;
      end
      default: ;
    endcase
    cmp_expected = DATA_WIDTH'(pattern(MAX_AW'(cmp_addr), mode_q, cmp_inv));
    wr_data      = DATA_WIDTH'(pattern(MAX_AW'(cnt), mode_q, state == RW1_WR));
  end

  // The idle port points at ~cnt so it never collides with the active address.
  always_comb begin
    addressA = '0;
    addressB = '0;
    dataInA  = '0;
    dataInB  = '0;
    weA      = 1'b0;
    weB      = 1'b0;
    case (state)
      W0, RW1_WR, RW2_WR: begin
        addressA = cnt;
        addressB = ~cnt;
        dataInA  = wr_data;
        weA      = 1'b1;
      end
      RW1_RD, RW2_RD: begin
        addressA = ~cnt;
        addressB = cnt;
      end
      R3: begin
        addressA = cnt;
        addressB = ~cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      mode_q <= MODE_SOLID;
      cnt    <= '0;
      drain  <= 1'b0;
      pass   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q <= mode_t'(mode);
          pass   <= 1'b0;
          cnt    <= '0;
          state  <= W0;
        end
        W0: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RW1_RD;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        RW1_RD: state <= RW1_WR;
        RW1_WR: begin
          if (cnt == LAST) begin
            state <= RW2_RD;
          end else begin
            cnt   <= cnt + ADDR_WIDTH'(1);
            state <= RW1_RD;
          end
        end
        RW2_RD: state <= RW2_WR;
        RW2_WR: begin
          if (cnt == '0) begin
            state <= R3;
          end else begin
            cnt   <= cnt - ADDR_WIDTH'(1);
            state <= RW2_RD;
          end
        end
        R3: begin
          if (drain) begin
            drain <= 1'b0;
            // Fold in the drain-cycle compare, which lands on this same edge.
            pass  <= (errorCount == '0) && !mismatch;
            state <= DONE;
          end else if (cnt == LAST) begin
            drain <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_test_checker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ERR_WIDTH (ERR_WIDTH)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .valid        (cmp_valid),
    .actual       (cmp_actual),
    .expected     (cmp_expected),
    .addr         (cmp_addr),
    .mismatch     (mismatch),
    .errorCount   (errorCount),
    .firstFailAddr(firstFailAddr)
  );

endmodule

// File: tb/tb_mem_march_tester.sv
// Directed bench: two tester instances, each with its own behavioural dual-port BRAM.
module tb_mem_march_tester;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Large instance: 16-bit data, 256 words, 16-bit error counter
  logic        start8 = 1'b0;
  logic [1:0]  mode8  = 2'd0;
  logic [7:0]  addressA8, addressB8, firstFail8;
  logic [15:0] dataInA8, dataInB8, dataOutA8, dataOutB8, errorCount8;
  logic        weA8, weB8, busy8, done8, pass8;
  logic [15:0] mem8 [256];
  logic [7:0]  fault8_addr = 8'h00;
  logic [15:0] fault8_mask = 16'h0000;

  mem_march_tester #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ERR_WIDTH(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8),
    .addressA(addressA8), .addressB(addressB8),
    .dataInA(dataInA8), .dataInB(dataInB8), .weA(weA8), .weB(weB8),
    .dataOutA(dataOutA8), .dataOutB(dataOutB8),
    .busy(busy8), .done(done8), .pass(pass8),
    .errorCount(errorCount8), .firstFailAddr(firstFail8)
  );

  always @(posedge clk) begin
    if (weA8) mem8[addressA8] <= dataInA8;
    if (weB8) mem8[addressB8] <= dataInB8;
    dataOutA8 <= mem8[addressA8] | ((addressA8 == fault8_addr) ? fault8_mask : 16'h0);
    dataOutB8 <= mem8[addressB8] | ((addressB8 == fault8_addr) ? fault8_mask : 16'h0);
  end

  // Small instance: 16 words, 2-bit error counter
  logic        start4 = 1'b0;
  logic [1:0]  mode4  = 2'd0;
  logic [3:0]  addressA4, addressB4, firstFail4;
  logic [15:0] dataInA4, dataInB4, dataOutA4, dataOutB4;
  logic [1:0]  errorCount4;
  logic        weA4, weB4, busy4, done4, pass4;
  logic [15:0] mem4 [16];
  logic [15:0] stuck4 [16];

  mem_march_tester #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ERR_WIDTH(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4),
    .addressA(addressA4), .addressB(addressB4),
    .dataInA(dataInA4), .dataInB(dataInB4), .weA(weA4), .weB(weB4),
    .dataOutA(dataOutA4), .dataOutB(dataOutB4),
    .busy(busy4), .done(done4), .pass(pass4),
    .errorCount(errorCount4), .firstFailAddr(firstFail4)
  );

  always @(posedge clk) begin
    if (weA4) mem4[addressA4] <= dataInA4;
    if (weB4) mem4[addressB4] <= dataInB4;
    dataOutA4 <= mem4[addressA4] | stuck4[addressA4];
    dataOutB4 <= mem4[addressB4] | stuck4[addressB4];
  end

  function automatic logic [15:0] pat(input logic [1:0] m, input logic [7:0] a);
    case (m)
      2'd1:    return a[0] ? 16'hAAAA : 16'h5555;
      2'd2:    return {8'h00, a};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs the large instance from a start pulse until done, an abort, or a cycle budget.
  task automatic run8(input logic [1:0] m, input int abort_at, input logic poke,
                      output int bc, output int dc, output int w0_bad);
    bc = 0; dc = 0; w0_bad = 0;
    mode8 = m; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] a;
      a = c[7:0];
      if (busy8) bc++;
      if (c < 256 && (!weA8 || addressA8 !== a || dataInA8 !== pat(m, a))) w0_bad++;
      if (done8) begin dc++; break; end
      if (poke) begin
        if (c == 20) start8 = 1'b1;
        if (c == 21) start8 = 1'b0;
        if (c == 30) mode8 = 2'd2;
      end
      if (c == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run4(input logic [1:0] m, output int bc, output int dc,
                      output int w0_bad, output int rw2_bad);
    bc = 0; dc = 0; w0_bad = 0; rw2_bad = 0;
    mode4 = m; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [7:0] a;
      a = c[7:0];
      if (busy4) bc++;
      if (c < 16 && (!weA4 || {4'h0, addressA4} !== a || dataInA4 !== pat(m, a))) w0_bad++;
      if (c >= 48 && c < 80 && ((c - 48) % 2) == 0 && int'(addressB4) != 15 - (c - 48) / 2)
        rw2_bad++;
      if (done4) begin dc++; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, dc, w0b, rw2b;
    for (int i = 0; i < 16; i++) stuck4[i] = 16'h0000;

    repeat (3) @(negedge clk);
    check("rst_busy",  busy8, 0);
    check("rst_done",  done8, 0);
    check("rst_pass",  pass8, 0);
    check("rst_err",   errorCount8, 0);
    check("rst_ffa",   firstFail8, 0);
    check("rst_we",    {weA8, weB8}, 0);
    check("rst_addr",  {addressA8, addressB8}, 0);
    check("rst_data",  {dataInA8, dataInB8}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Fault-free checkerboard run
    run8(2'd1, -1, 1'b0, bc, dc, w0b);
    check("m1_busy_cycles", bc, 1537);
    check("m1_done", dc, 1);
    check("m1_w0_pattern", w0b, 0);
    check("m1_pass", pass8, 1);
    check("m1_err", errorCount8, 0);
    check("m1_done_busy", busy8, 0);
    @(negedge clk);
    check("m1_done_pulse", done8, 0);

    // Bit 3 stuck at 1 on word 0x2A, solid pattern
    fault8_addr = 8'h2A; fault8_mask = 16'h0008;
    run8(2'd0, -1, 1'b0, bc, dc, w0b);
    check("flt_done", dc, 1);
    check("flt_pass", pass8, 0);
    check("flt_err", errorCount8, 2);
    check("flt_ffa", firstFail8, 8'h2A);
    fault8_mask = 16'h0000;
    @(negedge clk);

    // Restart attempt and mode change while busy
    run8(2'd1, -1, 1'b1, bc, dc, w0b);
    check("poke_w0_pattern", w0b, 0);
    check("poke_busy_cycles", bc, 1537);
    check("poke_pass", pass8, 1);
    check("poke_err_clr", errorCount8, 0);
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8 || busy8) dc++;
    end
    check("poke_single_run", dc, 0);
    mode8 = 2'd0;

    // Reset at cycle 300 of a run
    run8(2'd1, 300, 1'b0, bc, dc, w0b);
    check("abort_we", {weA8, weB8}, 0);
    check("abort_busy", busy8, 0);
    check("abort_pass", pass8, 0);
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8 || busy8) dc++;
      @(negedge clk);
    end
    check("abort_no_done", dc, 0);
    run8(2'd1, -1, 1'b0, bc, dc, w0b);
    check("rerun_done", dc, 1);
    check("rerun_busy_cycles", bc, 1537);
    check("rerun_pass", pass8, 1);
    @(negedge clk);

    // Small instance: five faulty words saturate the 2-bit counter
    stuck4[3] = 16'h0001; stuck4[5] = 16'h0001; stuck4[7] = 16'h0001;
    stuck4[9] = 16'h0001; stuck4[11] = 16'h0001;
    run4(2'd0, bc, dc, w0b, rw2b);
    check("sat_done", dc, 1);
    check("sat_err", errorCount4, 3);
    check("sat_pass", pass4, 0);
    check("sat_ffa", firstFail4, 3);
    for (int i = 0; i < 16; i++) stuck4[i] = 16'h0000;
    @(negedge clk);

    // Small instance: address-as-data, fault-free
    run4(2'd2, bc, dc, w0b, rw2b);
    check("m2_busy_cycles", bc, 97);
    check("m2_w0_data_eq_addr", w0b, 0);
    check("m2_rw2_descending", rw2b, 0);
    check("m2_pass", pass4, 1);
    check("m2_err", errorCount4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_march_tester.md
Name: mem_march_tester

Overview:
- Parametrised successor to the team's fixed-sequence BRAM exerciser.
- Runs a self-checking March test over a true dual-port BRAM of configurable width and depth, using both ports.
- Selectable data patterns; reports pass/fail, a saturating error count and the first failing address.
- Sits between the board top (start switch, seg7/LED status) and the dual-port BRAM instance.

Parameters:
- DATA_WIDTH, 16, BRAM word width.
- ADDR_WIDTH, 8, BRAM address width; depth N = 2**ADDR_WIDTH.
- ERR_WIDTH, 16, error counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- mode  in  2  pattern select: 0 = zeros/ones, 1 = 0x55../0xAA.. checkerboard, 2 = address-as-data (zero-extended)/inverse, 3 = reserved, treated as 0.
- addressA, addressB  out  ADDR_WIDTH  BRAM port addresses.
- dataInA, dataInB  out  DATA_WIDTH  BRAM write data.
- weA, weB  out  1  BRAM write enables.
- dataOutA, dataOutB  in  DATA_WIDTH  BRAM read data; registered, valid one clk after the address is presented.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  result of the last completed run.
- errorCount  out  ERR_WIDTH  mismatches in the current/last run.
- firstFailAddr  out  ADDR_WIDTH  address of the first mismatch.

Behaviour:
- Reset (rst=0 at posedge):
  - state <= IDLE.
  - weA = weB = 0; addresses and data = 0.
  - busy = done = 0; pass = 0; errorCount = 0; firstFailAddr = 0.
- Reset mid-run aborts; weA/weB are low from that edge onward. No partial result is reported.
- Memory-side outputs are Moore-decoded from the state and the address counter.
- Notation: P = base pattern(addr, mode); ~P = bitwise inverse.
- IDLE:
  - start=1 loads mode, clears errorCount/firstFailAddr/pass, and moves to W0.
  - start held high after DONE restarts the test.
- W0 (ascending, N cycles): port A writes P at addr i, i = 0..N-1.
- RW1 (ascending, 2 cycles/addr):
  - RD: port B reads addr i.
  - WR: port A writes ~P at addr i; dataOutB is compared against P in this cycle.
- RW2 (descending, i = N-1..0, 2 cycles/addr):
  - RD: port B reads addr i.
  - WR: port A writes P at addr i; dataOutB is compared against ~P.
- R3 (ascending, pipelined, N+1 cycles): port A reads addr i each cycle; dataOutA is compared against P of addr i-1 the next cycle; one drain cycle follows the last address.
- Port rules:
  - A read and a write never hit the same address on the same cycle.
  - The unused port has we=0 and data=0.
- DONE (1 cycle): done=1, busy=0, pass = (errorCount==0); then IDLE.
- busy is high exactly 6N+1 cycles per run.
- Address counter wraps are never reached. Phase transitions occur on the terminal count (N-1 ascending, 0 descending).
- Errors:
  - Each mismatching compare increments errorCount, saturating at all-ones.
  - firstFailAddr is captured only on the first mismatch of a run.
- start during busy is ignored. mode changes during busy are ignored (latched copy).

Decomposition:
- Package mem_test_pkg holds:
  - state enum: IDLE, W0, RW1_RD, RW1_WR, RW2_RD, RW2_WR, R3, DONE.
  - mode codes.
  - pattern function (addr, mode, invert) -> DATA_WIDTH word.
- Sub-module mem_test_checker:
  - inputs: compare-valid strobe, actual data, expected data, address.
  - owns errorCount (saturating) and firstFailAddr capture.
  - cleared by a start-accept strobe.

Test Plan:
- Fault-free 8-bit-addr BRAM model, mode=1, start pulse -> writes alternate 0x5555/0xAAAA; busy high 1537 cycles; done pulse; pass=1; errorCount=0.
- Bit 3 of addr 0x2A stuck-at-1, mode=0 -> pass=0; errorCount=2 (RW1 expects 0 reads 0x0008; R3 likewise; RW2 expects 0xFFFF, matches); firstFailAddr=0x2A.
- mode=2, ADDR_WIDTH=4, fault-free -> W0 writes data==address 0..15; RW2 addresses descend 15..0; pass=1 after 97 busy cycles.
- rst=0 at cycle 300 of a run -> weA=weB=0 from that edge; busy=0; no done pulse; a new start completes normally.
- start re-asserted during busy and mode changed mid-run -> ignored; run completes with the latched mode; done pulses once.
- ERR_WIDTH=2 with 5 injected faulty words -> errorCount saturates at 3; pass=0.
